// File: rtl/ival_frame_rx_if.sv
// Output handshake bundle for the ival frame receiver: one-entry buffer word
// with valid/ready flow control.
interface ival_frame_rx_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] ival;
  logic             ival_valid;
  logic             ival_ready;

  modport master (output ival, output ival_valid, input ival_ready);
  modport slave  (input ival, input ival_valid, output ival_ready);
endinterface

// File: rtl/ival_frame_rx.sv
// Serial MSB-first frame receiver with trailing even parity; good words land in
// a one-entry valid/ready buffer, parity failures and overflow drops are counted.
module ival_frame_rx #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 8
) (
  input  logic                 sysclk,
  input  logic                 reset,
  input  logic                 sin,
  input  logic                 sframe,
  ival_frame_rx_if.master      ival_bus,
  output logic                 perr,
  output logic                 ovf,
  output logic                 abort,
  output logic [CNTW-1:0]      err_cnt,
  output logic [CNTW-1:0]      drop_cnt,
  output logic                 busy
);
  typedef enum logic [1:0] {IDLE, DATA, PAR} state_t;

  localparam int              BW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNTW-1:0] CMAX = '1;

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [BW-1:0]    bitcnt;
  logic             par_ok;
  logic             consume;

  // In PAR the shift register holds the full word and sin is the parity bit.
  assign par_ok  = ~(^{sreg, sin});
  assign consume = ival_bus.ival_valid & ival_bus.ival_ready;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state               <= IDLE;
      sreg                <= '0;
      bitcnt              <= '0;
      ival_bus.ival       <= '0;
      ival_bus.ival_valid <= 1'b0;
      perr                <= 1'b0;
      ovf                 <= 1'b0;
      abort               <= 1'b0;
      err_cnt             <= '0;
      drop_cnt            <= '0;
      busy                <= 1'b0;
    end else begin
      perr  <= 1'b0;
      ovf   <= 1'b0;
      abort <= 1'b0;
      // A load later in this block overrides the clear (consume + load).
      if (consume) ival_bus.ival_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (sframe) begin
            sreg   <= WIDTH'(sin);
            bitcnt <= BW'(WIDTH - 2);
            state  <= (WIDTH == 1) ? PAR : DATA;
            busy   <= 1'b1;
          end
        end
        DATA: begin
          if (sframe) begin
            sreg   <= (sreg << 1) | WIDTH'(sin);
            bitcnt <= bitcnt - 1'b1;
            if (bitcnt == '0) state <= PAR;
          end else begin
            abort <= 1'b1;
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        PAR: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (!sframe) begin
            abort <= 1'b1;
          end else if (!par_ok) begin
            perr <= 1'b1;
            if (err_cnt != CMAX) err_cnt <= err_cnt + 1'b1;
          end else if (!ival_bus.ival_valid || ival_bus.ival_ready) begin
            ival_bus.ival       <= sreg;
            ival_bus.ival_valid <= 1'b1;
          end else begin
            ovf <= 1'b1;
            if (drop_cnt != CMAX) drop_cnt <= drop_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ival_frame_rx.sv
// Bench for ival_frame_rx: frame-level table, directed corner sequences and
// randomized traffic, all cross-checked every cycle against a bit-queue model.
module tb_ival_frame_rx;
  localparam int W  = 32;
  localparam int CW = 8;
  localparam int CMAXI = (1 << CW) - 1;

  logic          sysclk = 1'b0;
  logic          reset, sin, sframe;
  logic          perr, ovf, abort, busy;
  logic [CW-1:0] err_cnt, drop_cnt;

  int checks   = 0;
  int failures = 0;

  ival_frame_rx_if #(.WIDTH(W)) bus();

  ival_frame_rx #(.WIDTH(W), .CNTW(CW)) dut (
    .sysclk   (sysclk),
    .reset    (reset),
    .sin      (sin),
    .sframe   (sframe),
    .ival_bus (bus),
    .perr     (perr),
    .ovf      (ovf),
    .abort    (abort),
    .err_cnt  (err_cnt),
    .drop_cnt (drop_cnt),
    .busy     (busy)
  );

  always #5 sysclk = ~sysclk;

  // Reference model: frames are just the run of sframe-high bits collected so far.
  bit         m_bits[$];
  logic [W-1:0] m_ival;
  logic       m_valid, m_perr, m_ovf, m_abort;
  int         m_err, m_drop;

  function automatic void model_update(logic f, logic s, logic r, logic rst);
    logic [W-1:0] word;
    logic         p, loaded, consume;
    if (rst) begin
      m_bits.delete();
      m_ival = '0; m_valid = 0; m_perr = 0; m_ovf = 0; m_abort = 0;
      m_err = 0; m_drop = 0;
      return;
    end
    m_perr = 0; m_ovf = 0; m_abort = 0; loaded = 0;
    consume = m_valid && r;
    if (f) begin
      m_bits.push_back(s);
      if (m_bits.size() == W + 1) begin
        word = '0; p = 0;
        for (int i = 0; i < W; i++) word = (word << 1) | W'(m_bits[i]);
        foreach (m_bits[i]) p ^= m_bits[i];
        if (p) begin
          m_perr = 1;
          if (m_err < CMAXI) m_err++;
        end else if (!m_valid || r) begin
          m_ival = word; m_valid = 1; loaded = 1;
        end else begin
          m_ovf = 1;
          if (m_drop < CMAXI) m_drop++;
        end
        m_bits.delete();
      end
    end else if (m_bits.size() > 0) begin
      m_abort = 1;
      m_bits.delete();
    end
    if (consume && !loaded) m_valid = 0;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic f, input logic s, input logic r, input logic rst);
    sframe = f; sin = s; bus.ival_ready = r; reset = rst;
    @(posedge sysclk);
    model_update(f, s, r, rst);
    #1;
    chk("model_ival",  64'(bus.ival),       64'(m_ival));
    chk("model_valid", 64'(bus.ival_valid), 64'(m_valid));
    chk("model_perr",  64'(perr),           64'(m_perr));
    chk("model_ovf",   64'(ovf),            64'(m_ovf));
    chk("model_abort", 64'(abort),          64'(m_abort));
    chk("model_err",   64'(err_cnt),        64'(m_err));
    chk("model_drop",  64'(drop_cnt),       64'(m_drop));
    chk("model_busy",  64'(busy),           64'(m_bits.size() > 0));
  endtask

  task automatic send_frame(input logic [W-1:0] w, input logic p, input logic r, input logic rpar);
    for (int i = W - 1; i >= 0; i--) step(1'b1, w[i], r, 1'b0);
    step(1'b1, p, rpar, 1'b0);
  endtask

  typedef struct {
    logic [W-1:0]  word;
    logic          par;
    logic          rdy;
    logic          e_valid;
    logic [W-1:0]  e_ival;
    logic          e_perr;
    logic          e_ovf;
    logic [CW-1:0] e_err;
    logic [CW-1:0] e_drop;
  } vec_t;

  vec_t vt[6];

  logic [W-1:0] rw;
  logic         rp;
  int           cut, gap;

  initial begin
    vt[0] = '{32'hDEADBEEF, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 8'd0, 8'd0};
    vt[1] = '{32'h00000001, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 8'd1, 8'd0};
    vt[2] = '{32'h00000001, 1'b1, 1'b0, 1'b1, 32'h00000001, 1'b0, 1'b0, 8'd1, 8'd0};
    vt[3] = '{32'hCAFEF00D, 1'b0, 1'b0, 1'b1, 32'h00000001, 1'b0, 1'b1, 8'd1, 8'd1};
    vt[4] = '{32'hA5A5A5A5, 1'b0, 1'b1, 1'b1, 32'hA5A5A5A5, 1'b0, 1'b0, 8'd1, 8'd1};
    vt[5] = '{32'h12345678, 1'b1, 1'b1, 1'b1, 32'h12345678, 1'b0, 1'b0, 8'd1, 8'd1};

    sframe = 0; sin = 0; reset = 1; bus.ival_ready = 0;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_valid", 64'(bus.ival_valid), 64'd0);
    chk("rst_ival",  64'(bus.ival),       64'd0);
    chk("rst_busy",  64'(busy),           64'd0);
    chk("rst_err",   64'(err_cnt),        64'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Back-to-back frames from the table, checked right after each parity cycle.
    foreach (vt[i]) begin
      send_frame(vt[i].word, vt[i].par, vt[i].rdy, vt[i].rdy);
      chk($sformatf("tbl%0d_valid", i), 64'(bus.ival_valid), 64'(vt[i].e_valid));
      chk($sformatf("tbl%0d_ival", i),  64'(bus.ival),       64'(vt[i].e_ival));
      chk($sformatf("tbl%0d_perr", i),  64'(perr),           64'(vt[i].e_perr));
      chk($sformatf("tbl%0d_ovf", i),   64'(ovf),            64'(vt[i].e_ovf));
      chk($sformatf("tbl%0d_err", i),   64'(err_cnt),        64'(vt[i].e_err));
      chk($sformatf("tbl%0d_drop", i),  64'(drop_cnt),       64'(vt[i].e_drop));
    end

    // Consume and load in the same parity cycle: valid never drops.
    for (int i = W - 1; i >= 0; i--) begin
      step(1'b1, rw_bit(32'hCAFEF00D, i), 1'b0, 1'b0);
      chk("hs_valid_hold", 64'(bus.ival_valid), 64'd1);
      chk("hs_ival_hold",  64'(bus.ival),       64'h12345678);
    end
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("hs_valid", 64'(bus.ival_valid), 64'd1);
    chk("hs_ival",  64'(bus.ival),       64'hCAFEF00D);
    chk("hs_ovf",   64'(ovf),            64'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("hs_drain", 64'(bus.ival_valid), 64'd0);
    chk("hs_ival_kept", 64'(bus.ival),   64'hCAFEF00D);

    // Full buffer: second back-to-back word dropped.
    send_frame(32'h12345678, 1'b1, 1'b0, 1'b0);
    send_frame(32'hCAFEF00D, 1'b0, 1'b0, 1'b0);
    chk("ovf_pulse", 64'(ovf),      64'd1);
    chk("ovf_drop",  64'(drop_cnt), 64'd2);
    chk("ovf_ival",  64'(bus.ival), 64'h12345678);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("ovf_once",  64'(ovf),            64'd0);
    chk("ovf_xfer",  64'(bus.ival_valid), 64'd0);

    // Abort after 17 data bits, then a clean frame.
    for (int i = W - 1; i >= W - 17; i--) step(1'b1, rw_bit(32'h0F0F1234, i), 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("abort_pulse", 64'(abort), 64'd1);
    chk("abort_perr",  64'(perr),  64'd0);
    chk("abort_ovf",   64'(ovf),   64'd0);
    chk("abort_busy",  64'(busy),  64'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("abort_once",  64'(abort), 64'd0);
    send_frame(32'hA5A5A5A5, 1'b0, 1'b0, 1'b0);
    chk("abort_next_valid", 64'(bus.ival_valid), 64'd1);
    chk("abort_next_ival",  64'(bus.ival),       64'hA5A5A5A5);

    // Reset mid-frame with err_cnt=3 and a word held.
    send_frame(32'h00000001, 1'b0, 1'b0, 1'b0);
    send_frame(32'h00000001, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_err", 64'(err_cnt), 64'd3);
    for (int i = W - 1; i >= 10; i--) step(1'b1, rw_bit(32'h55AA33CC, i), 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("mid_rst_valid", 64'(bus.ival_valid), 64'd0);
    chk("mid_rst_ival",  64'(bus.ival),       64'd0);
    chk("mid_rst_err",   64'(err_cnt),        64'd0);
    chk("mid_rst_drop",  64'(drop_cnt),       64'd0);
    chk("mid_rst_busy",  64'(busy),           64'd0);
    chk("mid_rst_pulse", 64'({perr, ovf, abort}), 64'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 260; n++) send_frame(32'h80000000, 1'b0, 1'b0, 1'b0);
    chk("err_sat", 64'(err_cnt), 64'd255);
    send_frame(32'h00000003, 1'b1, 1'b0, 1'b0);
    chk("err_sat_hold", 64'(err_cnt), 64'd255);

    // Randomized traffic: bad parity, aborts, gaps, random ready, rare resets.
    for (int n = 0; n < 200; n++) begin
      rw  = $urandom;
      rp  = ^rw;
      if ($urandom_range(3) == 0) rp = ~rp;
      cut = ($urandom_range(9) == 0) ? int'($urandom_range(W)) : W + 1;
      for (int i = 0; i < cut; i++)
        step(1'b1, (i < W) ? rw[W-1-i] : rp, 1'($urandom_range(1)), $urandom_range(63) == 0);
      gap = ($urandom_range(1) == 0) ? 0 : int'($urandom_range(3, 1));
      for (int g = 0; g < gap; g++) step(1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  function automatic logic rw_bit(input logic [W-1:0] w, input int i);
    return w[i];
  endfunction
endmodule

// File: doc/ival_frame_rx.md
Name: ival_frame_rx

Overview:
- Serial-to-parallel frame receiver that produces the 32-bit ival control word consumed by the clocked capture registers.
- Accepts a framed, MSB-first serial bitstream with a trailing even-parity bit.
- Checks parity and holds each good word in a one-entry output buffer with a valid/ready handshake.
- Counts parity errors and dropped words.

Parameters:
WIDTH, 32, data bits per frame; ival width.
CNTW, 8, width of the saturating error and drop counters.

Ports:
sysclk  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
sin  input  1  serial data bit; sampled every sysclk cycle while sframe is high.
sframe  input  1  frame-active qualifier.
ival  output  WIDTH  assembled word; stable while ival_valid is high.
ival_valid  output  1  buffer holds an unconsumed word.
ival_ready  input  1  consumer accepts the word when ival_valid and ival_ready are both high.
perr  output  1  one-cycle pulse on a parity failure.
ovf  output  1  one-cycle pulse when a good word is dropped because the buffer is full.
abort  output  1  one-cycle pulse when sframe falls mid-frame.
err_cnt  output  CNTW  saturating count of parity failures.
drop_cnt  output  CNTW  saturating count of overflow drops.
busy  output  1  high in DATA or PAR state.

Behaviour:
- Reset (sync, reset=1 at a rising edge):
  - FSM goes to IDLE.
  - ival, ival_valid, perr, ovf, abort, err_cnt, drop_cnt, busy and the shift register all go to 0.
  - Reset overrides every other event in that cycle, including mid-frame and handshake completion.
- FSM states: IDLE, DATA, PAR.
- IDLE:
  - sframe=1 means this cycle's sin is data bit WIDTH-1. Load it into the shift register, bitcnt=WIDTH-2, go to DATA.
  - Special case WIDTH=1: go directly to PAR.
  - sframe=0: stay in IDLE.
- DATA:
  - sframe=1: shift sin in at the LSB and decrement bitcnt. When the cycle samples bit 0 (bitcnt=0), go to PAR.
  - sframe=0: discard the partial word, pulse abort next cycle, go to IDLE. Counters are unchanged.
- PAR:
  - sframe=1: sin is the parity bit. Check: XOR of all WIDTH data bits and the parity bit must equal 0 (even parity).
  - sframe=0: abort, same handling as in DATA.
  - Always return to IDLE after PAR. A frame occupies exactly WIDTH+1 sframe-high cycles.
- Back-to-back frames: if sframe stays high, the cycle after PAR is IDLE and samples the first bit of the next frame. No gap cycle is required.
- Parity fail:
  - Discard the word.
  - perr=1 for the cycle after the parity bit.
  - err_cnt increments, saturating at 2^CNTW-1.
- Parity pass, buffer load:
  - The word loads into ival if ival_valid=0, or if ival_valid=1 and ival_ready=1 in the parity cycle (simultaneous consume and load).
  - ival_valid=1 in the cycle after the parity bit; latency is one cycle.
- Parity pass, buffer full:
  - Applies when ival_valid=1 and ival_ready=0 in the parity cycle.
  - The new word is dropped and the buffered word is preserved.
  - ovf pulses for one cycle; drop_cnt increments, saturating.
- Handshake:
  - ival_valid, once high, stays high until a cycle with ival_ready=1.
  - ival must not change while valid unless a simultaneous consume and load occurs.
  - When ival_valid=0, the value of ival_ready is ignored.
- ival holds its last value after consumption; there is no clear-on-read.
- perr, ovf and abort are registered pulses, mutually exclusive per frame, and never asserted for more than one cycle per event.
- busy = (state != IDLE), registered with the state.

Test Plan:
1. Frame 0xDEADBEEF MSB-first, parity bit 0, ival_ready=1 → ival_valid high one cycle after the parity bit, ival=0xDEADBEEF; perr=0; counters 0.
2. Frame 0x00000001 with parity 0 (wrong, correct is 1) → perr pulses once, ival_valid stays 0, err_cnt=1; a resend with parity 1 yields ival=0x00000001.
3. Two back-to-back frames 0x12345678 (parity 1) and 0xCAFEF00D (parity 0), ival_ready=0 → first word held valid, second dropped, ovf pulses, drop_cnt=1, ival=0x12345678. Raising ready then gives one transfer and valid=0.
4. ival_valid=1 with ival_ready=1 exactly in the parity cycle of a second good frame → no ovf, ival updates to the new word, valid stays high continuously.
5. sframe drops after 17 data bits → abort pulses once, no perr/ovf, FSM in IDLE; the next full frame 0xA5A5A5A5 (parity 0) is received correctly.
6. reset=1 for one cycle mid-frame (bit 10), with err_cnt=3 and a valid word held → next cycle all outputs 0, busy=0; 260 bad-parity frames → err_cnt saturates at 255.
